// File: rtl/arm_mc_controller.sv
// Multicycle ARMv4-subset control unit: main FSM, instruction/ALU decode, NZCV flags, condition logic.
// Define MC_CTRL_WAIT_EN to add the mem_ready input that stalls FETCH, MEMREAD and MEMWRITE.
module arm_mc_controller (
    input  logic        clk,
    input  logic        reset,
`ifdef MC_CTRL_WAIT_EN
    input  logic        mem_ready,
`endif
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUControl,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic        RegWrite,
    output logic [1:0]  RegSrc,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        unused_rn;

    logic        ready, stall;
    logic        nextpc, irw, regw, memw, branch, aluop, pcs;
    logic [1:0]  flagw;
    logic [3:0]  flags;
    logic        condex, condexr;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];

`ifdef MC_CTRL_WAIT_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    assign stall = ~ready & ((state == FETCH) | (state == MEMREAD) | (state == MEMWRITE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        nextpc     = 1'b0;
        irw        = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        branch     = 1'b0;
        aluop      = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        case (state)
            FETCH: begin
                irw       = ready;
                nextpc    = ready;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (ready) state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b00:   state_next = funct[5] ? EXECI : EXECR;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                state_next = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (ready) state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                regw       = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
                if (ready) state_next = FETCH;
            end
            EXECR: begin
                aluop      = 1'b1;
                state_next = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                aluop      = 1'b1;
                state_next = ALUWB;
            end
            ALUWB: begin
                regw       = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                branch     = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Unrecognised funct codes fall back to ADD with no flag update.
    always_comb begin
        ALUControl = 2'b00;
        flagw      = 2'b00;
        if (aluop) begin
            case (funct[4:1])
                4'b0100: begin ALUControl = 2'b00; flagw = {funct[0], funct[0]}; end
                4'b0010: begin ALUControl = 2'b01; flagw = {funct[0], funct[0]}; end
                4'b0000: begin ALUControl = 2'b10; flagw = {funct[0], 1'b0};     end
                4'b1100: begin ALUControl = 2'b11; flagw = {funct[0], 1'b0};     end
                default: begin ALUControl = 2'b00; flagw = 2'b00;                end
            endcase
        end
    end

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags;
        condex = 1'b0;
        case (cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = c;
            4'b0011: condex = ~c;
            4'b0100: condex = n;
            4'b0101: condex = ~n;
            4'b0110: condex = v;
            4'b0111: condex = ~v;
            4'b1000: condex = c & ~z;
            4'b1001: condex = ~(c & ~z);
            4'b1010: condex = (n == v);
            4'b1011: condex = (n != v);
            4'b1100: condex = ~z & (n == v);
            4'b1101: condex = z | (n != v);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags   <= '0;
            condexr <= 1'b0;
        end else begin
            if (aluop & flagw[1] & condex) flags[3:2] <= ALUFlags[3:2];
            if (aluop & flagw[0] & condex) flags[1:0] <= ALUFlags[1:0];
            if (!stall) condexr <= condex;
        end
    end

    assign pcs      = ((rd == 4'd15) & regw) | branch;
    assign PCWrite  = ~reset & (nextpc | (pcs & condexr));
    assign IRWrite  = ~reset & irw;
    assign RegWrite = ~reset & regw & condexr;
    assign MemWrite = ~reset & memw & condexr;
    assign ImmSrc   = op;
    assign RegSrc   = {op == 2'b01, op == 2'b10};
    assign State    = state;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed self-checking bench for arm_mc_controller; covers the MC_CTRL_WAIT_EN stall when that macro is defined.
module tb_arm_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0]  State;
`ifdef MC_CTRL_WAIT_EN
    logic        mem_ready = 1'b1;
`endif

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    arm_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
`ifdef MC_CTRL_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegWrite   (RegWrite),
        .RegSrc     (RegSrc),
        .State      (State)
    );

    always #5 clk = ~clk;

    logic [15:0] ctlv;
    assign ctlv = {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
                   ALUSrcA, ALUSrcB, RegWrite};

    function automatic logic [15:0] ctl(input logic [3:0] st, input logic pcw, input logic adr,
                                        input logic memw, input logic irw, input logic [1:0] res,
                                        input logic [1:0] alc, input logic asa,
                                        input logic [1:0] asb, input logic regw);
        return {st, pcw, adr, memw, irw, res, alc, asa, asb, regw};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tickin(input logic [19:0] ins, input logic [3:0] fl);
        @(posedge clk);
        #1;
        Instr    = ins;
        ALUFlags = fl;
        #1;
    endtask

    // Entered in FETCH; leaves the bench in the following FETCH.
    task automatic run_dp(input string tag, input logic [19:0] ins, input logic [3:0] fl,
                          input logic [3:0] exst, input logic [1:0] alc,
                          input logic [1:0] asb, input logic regw_exp);
        Instr = ins;
        #1;
        chk({tag, "_fetch"}, ctlv, ctl(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 1, 2'b10, 0));
        tickin(ins, 4'b0000);
        chk({tag, "_decode"}, ctlv, ctl(4'd1, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, 0));
        tickin(ins, fl);
        chk({tag, "_exec"}, ctlv, ctl(exst, 0, 0, 0, 0, 2'b00, alc, 0, asb, 0));
        tickin(ins, 4'b0000);
        chk({tag, "_aluwb"}, ctlv, ctl(4'd8, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, regw_exp));
        tickin(ins, 4'b0000);
    endtask

    task automatic run_beq(input string tag, input logic taken);
        Instr = 20'h0A000;
        #1;
        chk({tag, "_fetch"}, ctlv, ctl(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 1, 2'b10, 0));
        tickin(20'h0A000, 4'b0000);
        chk({tag, "_srcs"}, {12'd0, ImmSrc, RegSrc}, 16'h0009);
        tickin(20'h0A000, 4'b0000);
        chk({tag, "_branch"}, ctlv, ctl(4'd9, taken, 0, 0, 0, 2'b10, 2'b00, 0, 2'b01, 0));
        tickin(20'h0A000, 4'b0000);
        chk({tag, "_done"}, {12'd0, State}, 16'd0);
    endtask

    initial begin
        reset    = 1'b1;
        Instr    = 20'hE2802;
        ALUFlags = 4'b0000;
        #2;
        chk("reset_ctl", ctlv, ctl(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, 0));
        #6;
        reset = 1'b0;
        #1;

        // ADD R2,R0,#5: immediate DP, writes back unconditionally
        run_dp("add_imm", 20'hE2802, 4'b0000, 4'd7, 2'b00, 2'b01, 1'b1);
        chk("add_imm_end", {12'd0, State}, 16'd0);

        // SUBS R3,R3,R3 with the ALU reporting Z=1,C=1
        run_dp("subs", 20'hE0533, 4'b0110, 4'd6, 2'b01, 2'b00, 1'b1);
        run_dp("addeq", 20'h02802, 4'b0000, 4'd7, 2'b00, 2'b01, 1'b1);
        run_dp("addne", 20'h12802, 4'b0000, 4'd7, 2'b00, 2'b01, 1'b0);
        run_dp("addcs", 20'h22802, 4'b0000, 4'd7, 2'b00, 2'b01, 1'b1);
        run_dp("addmi", 20'h42802, 4'b0000, 4'd7, 2'b00, 2'b01, 1'b0);

        // LDR R1,[R0,#8]
        Instr = 20'hE5901;
        #1;
        chk("ldr_fetch", ctlv, ctl(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 1, 2'b10, 0));
        tickin(20'hE5901, 4'b0000);
        chk("ldr_srcs", {12'd0, ImmSrc, RegSrc}, 16'h0006);
        tickin(20'hE5901, 4'b0000);
        chk("ldr_memadr", ctlv, ctl(4'd2, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0));
        tickin(20'hE5901, 4'b0000);
        chk("ldr_memread", ctlv, ctl(4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0));
        tickin(20'hE5901, 4'b0000);
        chk("ldr_memwb", ctlv, ctl(4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 0, 2'b00, 1));
        tickin(20'hE5901, 4'b0000);
        chk("ldr_end", {12'd0, State}, 16'd0);

        // STR R7,[R3,#84]
        Instr = 20'hE5837;
        #1;
        tickin(20'hE5837, 4'b0000);
        tickin(20'hE5837, 4'b0000);
        chk("str_memadr", ctlv, ctl(4'd2, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0));
        tickin(20'hE5837, 4'b0000);
        chk("str_memwrite", ctlv, ctl(4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 0, 2'b00, 0));
        chk("str_regsrc", {14'd0, RegSrc}, 16'h0002);
        tickin(20'hE5837, 4'b0000);
        chk("str_end", {12'd0, State}, 16'd0);

        // Clear Z, then BEQ must not redirect the PC
        run_dp("subs_clr", 20'hE0533, 4'b0000, 4'd6, 2'b01, 2'b00, 1'b1);
        run_beq("beq_nt", 1'b0);
        // Set Z, then BEQ is taken
        run_dp("subs_z", 20'hE0533, 4'b0100, 4'd6, 2'b01, 2'b00, 1'b1);
        run_beq("beq_t", 1'b1);

        // Reset while in MEMADR of an LDR
        Instr = 20'hE5901;
        #1;
        tickin(20'hE5901, 4'b0000);
        tickin(20'hE5901, 4'b0000);
        chk("rst_pre_memadr", {12'd0, State}, 16'd2);
        reset = 1'b1;
        #1;
        chk("rst_async", ctlv, ctl(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, 0));
        @(posedge clk);
        #2;
        chk("rst_held", ctlv, ctl(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, 0));
        reset = 1'b0;
        #1;
        chk("rst_release", ctlv, ctl(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 1, 2'b10, 0));
        // Flags were cleared by reset, so ADDEQ must not write back
        run_dp("addeq_after_rst", 20'h02802, 4'b0000, 4'd7, 2'b00, 2'b01, 1'b0);

`ifdef MC_CTRL_WAIT_EN
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("wait_fetch_hold", ctlv, ctl(4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 1, 2'b10, 0));
            @(posedge clk);
            #2;
        end
        mem_ready = 1'b1;
        #1;
        chk("wait_fetch_ready", ctlv, ctl(4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 1, 2'b10, 0));
        @(posedge clk);
        #2;
        chk("wait_decode", {12'd0, State}, 16'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
